// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared width, FSM state codes and sizing helper for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_I_XFER = 2'd1;
    localparam logic [1:0] ARB_D_XFER = 2'd2;

    // Counter/index width that stays at least one bit even for a count of 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_xfer_counter.sv
// rtl/mem_port_arbiter_xfer_counter.sv - latency counter and word index for one port transfer
module xfer_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LINE_WORDS  = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                run,
    output logic [idx_width(LINE_WORDS)-1:0]    idx,
    output logic                                beat_last,
    output logic                                line_last
);

    localparam int IDX_W = idx_width(LINE_WORDS);
    localparam int LAT_W = idx_width(MEM_LATENCY);

    logic [LAT_W-1:0] lat;

    assign beat_last = (lat == LAT_W'(MEM_LATENCY - 1));
    assign line_last = beat_last && (idx == IDX_W'(LINE_WORDS - 1));

    // Held at zero whenever not running, so every transfer starts from word 0, cycle 0.
    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            lat <= '0;
            idx <= '0;
        end else if (beat_last) begin
            lat <= '0;
            idx <= line_last ? '0 : idx + 1'b1;
        end else begin
            lat <= lat + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the external memory port between I-fetch line fills and D-side accesses
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE   = mem_port_arbiter_pkg::WORD_SIZE,
    parameter int LINE_WORDS  = 4,
    parameter int MEM_LATENCY = 2
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                i_req,
    input  logic [WORD_SIZE-1:0]                i_addr,
    input  logic                                d_req,
    input  logic                                d_we,
    input  logic [WORD_SIZE-1:0]                d_addr,
    input  logic [WORD_SIZE-1:0]                d_wdata,
    output logic                                gnt_i,
    output logic                                gnt_d,
    output logic                                rvalid,
    output logic [idx_width(LINE_WORDS)-1:0]    ridx,
    output logic [WORD_SIZE-1:0]                rdata,
    output logic                                i_done,
    output logic                                d_done,
    output logic                                mem_read,
    output logic                                mem_write,
    output logic [WORD_SIZE-1:0]                mem_addr,
    output logic [WORD_SIZE-1:0]                mem_wdata,
    input  logic [WORD_SIZE-1:0]                mem_rdata
);

    localparam int IDX_W = idx_width(LINE_WORDS);

    logic [1:0]           state;
    logic                 last_d;
    logic                 cap_we;
    logic [WORD_SIZE-1:0] cap_addr;
    logic [WORD_SIZE-1:0] cap_wdata;
    logic [IDX_W-1:0]     idx;
    logic                 beat_last;
    logic                 line_last;
    logic                 busy;
    logic                 xfer_done;
    logic [WORD_SIZE-1:0] line_base;

    assign busy      = (state != ARB_IDLE);
    assign xfer_done = ((state == ARB_I_XFER) && line_last) ||
                       ((state == ARB_D_XFER) && (cap_we ? beat_last : line_last));
    assign line_base = cap_addr & ~WORD_SIZE'(LINE_WORDS - 1);

    xfer_counter #(
        .LINE_WORDS  (LINE_WORDS),
        .MEM_LATENCY (MEM_LATENCY)
    ) u_xfer_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (busy && !xfer_done),
        .idx       (idx),
        .beat_last (beat_last),
        .line_last (line_last)
    );

    // On a conflict D wins unless D owned the previous completed grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ARB_IDLE;
            last_d    <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (d_req && (!i_req || !last_d)) begin
                        state     <= ARB_D_XFER;
                        cap_we    <= d_we;
                        cap_addr  <= d_addr;
                        cap_wdata <= d_wdata;
                    end else if (i_req) begin
                        state     <= ARB_I_XFER;
                        cap_we    <= 1'b0;
                        cap_addr  <= i_addr;
                        cap_wdata <= '0;
                    end
                end
                ARB_I_XFER: begin
                    if (xfer_done) begin
                        state  <= ARB_IDLE;
                        last_d <= 1'b0;
                    end
                end
                ARB_D_XFER: begin
                    if (xfer_done) begin
                        state  <= ARB_IDLE;
                        last_d <= 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_i     = (state == ARB_I_XFER);
        gnt_d     = (state == ARB_D_XFER);
        mem_write = gnt_d && cap_we;
        mem_read  = gnt_i || (gnt_d && !cap_we);
        rvalid    = mem_read && beat_last;
        ridx      = rvalid ? idx : '0;
        rdata     = rvalid ? mem_rdata : '0;
        i_done    = gnt_i && xfer_done;
        d_done    = gnt_d && xfer_done;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_write) begin
            mem_addr  = cap_addr;
            mem_wdata = cap_wdata;
        end else if (mem_read) begin
            mem_addr  = line_base + WORD_SIZE'(idx);
        end
    end

endmodule
